clint_ctrl: RTL and testbench
=============================

Name: clint_ctrl

Overview:
- Core-local interrupt/trap sequencer that drives the CSR file's clint-side write port.
- On ecall, ebreak, mret or an enabled external/timer interrupt it:
  - stalls the pipeline;
  - performs the required CSR updates (mepc, mstatus, mcause) one per cycle;
  - issues a single-cycle redirect of the PC to mtvec or mepc.
- Sits between decode/execute (trap sources), the CSR file (consumer of its writes, provider of mtvec/mepc/mstatus and global interrupt enable) and the PC/ctrl stage.

Parameters:
- INT_LINES, 8, number of interrupt request lines; bit 0 is the timer interrupt.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- inst_addr_i  in  32  address of the instruction currently in execute
- inst_ecall_i  in  1  execute holds ECALL
- inst_ebreak_i  in  1  execute holds EBREAK
- inst_mret_i  in  1  execute holds MRET
- jump_flag_i  in  1  execute is redirecting this cycle
- jump_addr_i  in  32  redirect target from execute
- int_flag_i  in  INT_LINES  level interrupt requests
- global_int_en_i  in  1  mstatus.MIE from the CSR file
- csr_mtvec_i  in  32  live mtvec
- csr_mepc_i  in  32  live mepc
- csr_mstatus_i  in  32  live mstatus
- we_o  out  1  CSR write enable (clint side)
- waddr_o  out  32  CSR write address; bits [31:12] zero
- data_o  out  32  CSR write data
- hold_flag_o  out  1  stall request to pipeline control
- int_assert_o  out  1  one-cycle PC redirect strobe
- int_addr_o  out  32  redirect target

Behaviour:
- Reset (async, rst=1):
  - state=S_IDLE.
  - All latched registers cleared.
  - we_o=0, waddr_o=0, data_o=0, int_assert_o=0, int_addr_o=0, hold_flag_o=0.
  - Reset mid-sequence abandons the sequence; no partial write is completed.
- States: S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET, S_JUMP.
- Trap detection is evaluated only in S_IDLE. Priority: ecall > ebreak > mret > interrupt.
- Interrupt is taken only if global_int_en_i=1 and int_flag_i≠0.
- Detection cycle (S_IDLE) latches cause_q and epc_q:
  - ecall: cause 32'd11, epc=inst_addr_i.
  - ebreak: cause 32'd3, epc=inst_addr_i.
  - interrupt with int_flag_i[0]=1: cause 32'h8000_0007.
  - any other interrupt line: cause 32'h8000_000B.
  - interrupt epc = jump_addr_i if jump_flag_i=1, else inst_addr_i.
- Next state after detection:
  - trap or interrupt → S_MEPC.
  - mret → S_MRET.
- hold_flag_o = detect | (state≠S_IDLE). It is combinational, so the pipeline stalls from the detection cycle.
- S_MEPC: we_o=1, waddr_o=0x341, data_o=epc_q → S_MSTATUS.
- S_MSTATUS:
  - we_o=1, waddr_o=0x300.
  - data_o = csr_mstatus_i with bit7 (MPIE) := bit3 (MIE) and bit3 := 0; all other bits unchanged.
  - → S_MCAUSE.
- S_MCAUSE: we_o=1, waddr_o=0x342, data_o=cause_q → S_JUMP; target_q={csr_mtvec_i[31:2],2'b00} (direct mode only).
- S_MRET:
  - we_o=1, waddr_o=0x300.
  - data_o = csr_mstatus_i with bit3 := bit7 and bit7 := 1.
  - target_q=csr_mepc_i.
  - → S_JUMP.
- S_JUMP: we_o=0, int_assert_o=1, int_addr_o=target_q → S_IDLE.
- we_o, int_assert_o and int_addr_o are decoded from the state register only; there is no input-to-output path except hold_flag_o.
- Latency from detection to int_assert_o:
  - trap/interrupt: 4 cycles (3 CSR writes).
  - mret: 2 cycles.
- Requests arriving while state≠S_IDLE are ignored. Sync requests persist because the pipeline is held; interrupts are level and are re-sampled in S_IDLE.
- The CSR file gives execute-side writes priority. This block requires the pipeline hold to suppress execute CSR writes from S_MEPC onward.
- In S_IDLE with no request, all outputs are 0.

Decomposition:
- Shared package:
  - CSR addresses (MEPC 0x341, MSTATUS 0x300, MCAUSE 0x342, MTVEC 0x305);
  - cause codes (11, 3, 0x8000_0007, 0x8000_000B);
  - state encoding;
  - mstatus bit indices MIE=3, MPIE=7.
- One sub-module: clint_trap_arb. It is combinational and performs priority select plus cause/epc generation from the request inputs.

Test Plan:
- Ecall: inst_addr_i=0x100, ecall=1, mtvec=0x200, mstatus=0x8 → writes, in order:
  - mepc=0x100;
  - mstatus=0x80;
  - mcause=11.
  - Then int_assert_o=1 with int_addr_o=0x200 four cycles after detect; hold_flag_o high for 5 cycles.
- Timer interrupt: global_int_en_i=1, int_flag_i=8'h01, jump_flag_i=1, jump_addr_i=0x340 → mepc=0x340, mcause=0x8000_0007, redirect to {mtvec[31:2],00} with mtvec=0x203 giving 0x200.
- Masked interrupt: global_int_en_i=0, int_flag_i=8'h02 → no write, hold_flag_o=0. Then assert enable → mcause=0x8000_000B.
- Mret: mstatus=0x80, mepc=0x104, mret=1 → mstatus write 0x88, then int_assert_o with int_addr_o=0x104, two cycles after detect.
- Simultaneous ecall and int_flag_i=1 with enable → ecall wins (mcause=11). The interrupt is taken after returning to S_IDLE while the flag stays high.
- Reset asserted during S_MSTATUS → outputs zero immediately (async), state S_IDLE; no mcause write occurs.

Source files
------------

// File: rtl/clint_ctrl_pkg.sv
// clint_ctrl_pkg: CSR addresses, trap causes, sequencer states and mstatus helpers for the clint.
package clint_ctrl_pkg;
    localparam logic [31:0] CSR_MEPC    = 32'h341;
    localparam logic [31:0] CSR_MSTATUS = 32'h300;
    localparam logic [31:0] CSR_MCAUSE  = 32'h342;
    localparam logic [31:0] CSR_MTVEC   = 32'h305;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
    localparam int MIE  = 3;
    localparam int MPIE = 7;
    typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET, S_JUMP} state_t;
    function automatic logic [31:0] trap_status(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MPIE] = s[MIE];
        r[MIE] = 1'b0;
        return r;
    endfunction
    function automatic logic [31:0] mret_status(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MIE] = s[MPIE];
        r[MPIE] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/clint_trap_arb.sv
// clint_trap_arb: priority select among ecall/ebreak/mret/interrupt with cause and epc generation.
module clint_trap_arb
    import clint_ctrl_pkg::*;
#(
    parameter int INT_LINES = 8
) (
    input  logic                 ecall,
    input  logic                 ebreak,
    input  logic                 mret,
    input  logic [INT_LINES-1:0] int_flag,
    input  logic                 global_int_en,
    input  logic [31:0]          inst_addr,
    input  logic                 jump_flag,
    input  logic [31:0]          jump_addr,
    output logic                 trap,
    output logic                 mret_take,
    output logic [31:0]          cause,
    output logic [31:0]          epc
);
    logic sync;
    logic irq;
    assign sync      = ecall | ebreak;
    assign irq       = global_int_en & (|int_flag);
    assign trap      = sync | (irq & ~mret);
    assign mret_take = mret & ~sync;
    assign cause     = ecall ? CAUSE_ECALL : ebreak ? CAUSE_EBREAK : int_flag[0] ? CAUSE_TIMER : CAUSE_EXT;
    // An interrupt arriving under a taken branch must resume at the branch target.
    assign epc       = (sync | ~jump_flag) ? inst_addr : jump_addr;
endmodule

// File: rtl/clint_ctrl.sv
// clint_ctrl: trap/interrupt sequencer issuing mepc/mstatus/mcause writes and a PC redirect.
module clint_ctrl
    import clint_ctrl_pkg::*;
#(
    parameter int INT_LINES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_addr_i,
    input  logic                 inst_ecall_i,
    input  logic                 inst_ebreak_i,
    input  logic                 inst_mret_i,
    input  logic                 jump_flag_i,
    input  logic [31:0]          jump_addr_i,
    input  logic [INT_LINES-1:0] int_flag_i,
    input  logic                 global_int_en_i,
    input  logic [31:0]          csr_mtvec_i,
    input  logic [31:0]          csr_mepc_i,
    input  logic [31:0]          csr_mstatus_i,
    output logic                 we_o,
    output logic [31:0]          waddr_o,
    output logic [31:0]          data_o,
    output logic                 hold_flag_o,
    output logic                 int_assert_o,
    output logic [31:0]          int_addr_o
);
    state_t      state;
    logic [31:0] cause_q;
    logic        trap;
    logic        mret_take;
    logic [31:0] cause;
    logic [31:0] epc;

    clint_trap_arb #(.INT_LINES(INT_LINES)) u_arb (
        .ecall(inst_ecall_i),
        .ebreak(inst_ebreak_i),
        .mret(inst_mret_i),
        .int_flag(int_flag_i),
        .global_int_en(global_int_en_i),
        .inst_addr(inst_addr_i),
        .jump_flag(jump_flag_i),
        .jump_addr(jump_addr_i),
        .trap(trap),
        .mret_take(mret_take),
        .cause(cause),
        .epc(epc)
    );

    assign hold_flag_o = trap | mret_take | (state != S_IDLE);

    // Outputs are registered against the state being entered, so they are valid for that whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cause_q      <= '0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
        end else begin
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
            case (state)
                S_IDLE: begin
                    if (trap) begin
                        state   <= S_MEPC;
                        cause_q <= cause;
                        we_o    <= 1'b1;
                        waddr_o <= CSR_MEPC;
                        data_o  <= epc;
                    end else if (mret_take) begin
                        state   <= S_MRET;
                        we_o    <= 1'b1;
                        waddr_o <= CSR_MSTATUS;
                        data_o  <= mret_status(csr_mstatus_i);
                    end
                end
                S_MEPC: begin
                    state   <= S_MSTATUS;
                    we_o    <= 1'b1;
                    waddr_o <= CSR_MSTATUS;
                    data_o  <= trap_status(csr_mstatus_i);
                end
                S_MSTATUS: begin
                    state   <= S_MCAUSE;
                    we_o    <= 1'b1;
                    waddr_o <= CSR_MCAUSE;
                    data_o  <= cause_q;
                end
                S_MCAUSE: begin
                    state        <= S_JUMP;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= csr_mtvec_i & ~32'h3;
                end
                S_MRET: begin
                    state        <= S_JUMP;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= csr_mepc_i;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_ctrl.sv
// tb_clint_ctrl: directed stimulus checked against a per-cycle schedule model plus literal expectations.
module tb_clint_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] inst_addr = 0;
    logic        ecall = 0, ebreak = 0, mret = 0, jump_flag = 0;
    logic [31:0] jump_addr = 0;
    logic [7:0]  int_flag = 0;
    logic        gie = 0;
    logic [31:0] mtvec = 0, mepc = 0, mstatus = 0;
    logic        we, hold, int_assert;
    logic [31:0] waddr, data, int_addr;
    int checks = 0;
    int errors = 0;

    clint_ctrl #(.INT_LINES(8)) dut (
        .clk(clk), .rst(rst),
        .inst_addr_i(inst_addr), .inst_ecall_i(ecall), .inst_ebreak_i(ebreak), .inst_mret_i(mret),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .int_flag_i(int_flag),
        .global_int_en_i(gie), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
        .we_o(we), .waddr_o(waddr), .data_o(data), .hold_flag_o(hold),
        .int_assert_o(int_assert), .int_addr_o(int_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a detected request schedules the exact per-cycle outputs of the following cycles.
    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] data;
        logic        as;
        logic [31:0] addr;
    } ent_t;
    ent_t q[$];

    function automatic ent_t wr(input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e = '{1'b1, a, d, 1'b0, 32'h0};
        return e;
    endfunction

    function automatic ent_t jmp(input logic [31:0] a);
        ent_t e;
        e = '{1'b0, 32'h0, 32'h0, 1'b1, a};
        return e;
    endfunction

    always @(negedge clk) begin
        ent_t e;
        logic busy, det, irq;
        logic [31:0] c, pc, ms;
        if (rst) q.delete();
        else begin
            busy = q.size() != 0;
            e = busy ? q.pop_front() : '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
            irq = gie && int_flag != 0;
            det = !busy && (ecall || ebreak || mret || irq);
            chk("m_hold", {31'b0, hold}, {31'b0, busy | det});
            chk("m_we", {31'b0, we}, {31'b0, e.we});
            chk("m_waddr", waddr, e.waddr);
            chk("m_data", data, e.data);
            chk("m_assert", {31'b0, int_assert}, {31'b0, e.as});
            chk("m_addr", int_addr, e.addr);
            if (det) begin
                if (mret && !ecall && !ebreak) begin
                    ms = (mstatus & ~32'h8) | ((mstatus >> 4) & 32'h8) | 32'h80;
                    q.push_back(wr(32'h300, ms));
                    q.push_back(jmp(mepc));
                end else begin
                    c = ecall ? 32'd11 : ebreak ? 32'd3 : int_flag[0] ? 32'h8000_0007 : 32'h8000_000B;
                    pc = (!ecall && !ebreak && jump_flag) ? jump_addr : inst_addr;
                    ms = (mstatus & ~32'h88) | ((mstatus & 32'h8) << 4);
                    q.push_back(wr(32'h341, pc));
                    q.push_back(wr(32'h300, ms));
                    q.push_back(wr(32'h342, c));
                    q.push_back(jmp({mtvec[31:2], 2'b00}));
                end
            end
        end
    end

    initial begin
        step();
        chk("rst_we", {31'b0, we}, 0);
        chk("rst_hold", {31'b0, hold}, 0);
        chk("rst_addr", int_addr, 0);
        rst = 0;
        step();
        // ecall
        inst_addr = 32'h100; ecall = 1; mtvec = 32'h200; mstatus = 32'h8;
        #1;
        chk("ec_hold_det", {31'b0, hold}, 1);
        step(); chk("ec_mepc_a", waddr, 32'h341); chk("ec_mepc_d", data, 32'h100);
        step(); chk("ec_ms_a", waddr, 32'h300); chk("ec_ms_d", data, 32'h80);
        step(); chk("ec_mc_a", waddr, 32'h342); chk("ec_mc_d", data, 32'd11);
        step(); chk("ec_as", {31'b0, int_assert}, 1); chk("ec_addr", int_addr, 32'h200);
        chk("ec_we_jump", {31'b0, we}, 0);
        ecall = 0;
        step(); chk("ec_hold_end", {31'b0, hold}, 0); chk("ec_as_end", {31'b0, int_assert}, 0);
        // timer interrupt under a taken branch
        gie = 1; int_flag = 8'h01; jump_flag = 1; jump_addr = 32'h340; mtvec = 32'h203;
        step(); chk("tm_mepc", data, 32'h340);
        step();
        step(); chk("tm_cause", data, 32'h8000_0007);
        step(); chk("tm_addr", int_addr, 32'h200);
        int_flag = 0; jump_flag = 0;
        step();
        // masked interrupt, then enabled
        gie = 0; int_flag = 8'h02;
        #1;
        chk("mk_hold", {31'b0, hold}, 0);
        step(); chk("mk_we", {31'b0, we}, 0);
        step();
        gie = 1;
        step(); chk("ext_mepc_a", waddr, 32'h341);
        step();
        step(); chk("ext_cause", data, 32'h8000_000B);
        step();
        int_flag = 0; gie = 0;
        step();
        // mret
        mstatus = 32'h80; mepc = 32'h104; mret = 1;
        step(); chk("mr_a", waddr, 32'h300); chk("mr_d", data, 32'h88);
        step(); chk("mr_as", {31'b0, int_assert}, 1); chk("mr_addr", int_addr, 32'h104);
        mret = 0;
        step();
        // ecall beats a simultaneous timer interrupt; interrupt follows
        mstatus = 32'h8; mtvec = 32'h200; inst_addr = 32'h100; ecall = 1; gie = 1; int_flag = 8'h01;
        step();
        step();
        step(); chk("pr_cause", data, 32'd11);
        step(); ecall = 0;
        step(); chk("pr_int_hold", {31'b0, hold}, 1);
        step(); chk("pr_int_epc", data, 32'h100);
        step();
        step(); chk("pr_int_cause", data, 32'h8000_0007);
        step();
        int_flag = 0; gie = 0;
        step();
        // reset in S_MSTATUS
        ecall = 1; inst_addr = 32'h180;
        step();
        step(); chk("rs_ms_a", waddr, 32'h300);
        #2 rst = 1; ecall = 0;
        #1;
        chk("rs_we", {31'b0, we}, 0); chk("rs_waddr", waddr, 0); chk("rs_data", data, 0);
        chk("rs_hold", {31'b0, hold}, 0);
        step(); rst = 0;
        step(); chk("rs_no_mc", {31'b0, we}, 0);
        step(); chk("rs_no_as", {31'b0, int_assert}, 0);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
